// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the write-response interconnect slice:
//   resp_t      - AXI BRESP encoding
//   RESP_W      - width of a response field
//   clog2_min1  - index width helper that never returns zero
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Bits needed to index n items; at least one so a single-entry select is still a real signal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
// Round-robin arbiter over N requesters. The search begins at the stored
// pointer; when 'advance' is high and someone wins, the pointer moves to the
// requester after the winner (wrapping N-1 -> 0).
// Ports:
//   ACLK, ARESETn  clock, asynchronous active-low reset (pointer -> 0)
//   req[N]         request vector
//   advance        the consumer takes the current winner this cycle
//   grant[N]       one-hot winner (all zero when no request)
//   grant_idx      binary index of the winner
//   any_grant      a winner exists
// ---------------------------------------------------------------------------
module axi_rr_arbiter
    import axi_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = clog2_min1(N)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] ptr_r;
    logic [N-1:0]  grant_s;
    logic [IW-1:0] grant_idx_s;
    logic          found_s;
    logic [IW-1:0] idx_s;
    int            sum_s;

    // Rotating priority search: first active request at or after ptr_r.
    always_comb begin
        grant_s     = {N{1'b0}};
        grant_idx_s = {IW{1'b0}};
        found_s     = 1'b0;
        idx_s       = {IW{1'b0}};
        sum_s       = 0;
        for (int k = 0; k < N; k++) begin
            sum_s = int'(ptr_r) + k;
            idx_s = IW'((sum_s >= N) ? (sum_s - N) : sum_s);
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                grant_idx_s    = idx_s;
            end else begin
            end
        end
    end

    // Pointer moves only when a grant is actually consumed.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_r <= {IW{1'b0}};
        end else if (advance && found_s) begin
            ptr_r <= (grant_idx_s == IW'(N - 1)) ? {IW{1'b0}} : (grant_idx_s + IW'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;
    assign any_grant = found_s;

endmodule

// File: rtl/axi_bresp_router.sv
// ---------------------------------------------------------------------------
// axi_bresp_router
// Write-response (B channel) crossbar from NS slaves to NM masters. Each beat
// is steered by the master index embedded in the slave-side BID, so many
// writes may be outstanding. Each master has a round-robin arbiter over the
// slaves plus its own DECERR queue (requester NS), feeding a one-deep
// registered output slice.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   BID_S/BRESP_S/BVALID_S slave-side B beats (slave s at s*SIDW / s*2 / s)
//   BREADY_S               ready back to each slave (combinational)
//   BID_M/BRESP_M/BVALID_M master-side B beats (registered)
//   BREADY_M               master ready
//   decerr_push/decerr_id  default slave finished a write from master m with AWID
//   decerr_full            DECERR queue of master m is full
//   err_bad_id             sticky: a slave returned a master index >= NM
// ---------------------------------------------------------------------------
module axi_bresp_router
    import axi_pkg::*;
#(
    parameter int NM           = 2,
    parameter int NS           = 2,
    parameter int IDW          = 4,
    parameter int SIDW         = 8,
    parameter int DECERR_DEPTH = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [NS*SIDW-1:0]     BID_S,
    input  logic [NS*RESP_W-1:0]   BRESP_S,
    input  logic [NS-1:0]          BVALID_S,
    output logic [NS-1:0]          BREADY_S,
    output logic [NM*IDW-1:0]      BID_M,
    output logic [NM*RESP_W-1:0]   BRESP_M,
    output logic [NM-1:0]          BVALID_M,
    input  logic [NM-1:0]          BREADY_M,
    input  logic [NM-1:0]          decerr_push,
    input  logic [NM*IDW-1:0]      decerr_id,
    output logic [NM-1:0]          decerr_full,
    output logic                   err_bad_id
);

    localparam int MIW = clog2_min1(NM);
    localparam int GW  = clog2_min1(NS + 1);
    localparam int AW  = clog2_min1(DECERR_DEPTH);
    localparam int CW  = $clog2(DECERR_DEPTH) + 1;

    logic [MIW-1:0]       midx_s [NS];
    logic [NS-1:0]        bad_s;
    logic [NM-1:0]        load_all_s;
    logic [NM-1:0][NS:0]  grant_all_s;
    logic [NS-1:0]        bready_s;
    logic                 err_bad_id_r;

    // Extract the master index of each slave beat and flag out-of-range ones.
    always_comb begin
        bad_s = {NS{1'b0}};
        for (int s = 0; s < NS; s++) begin
            midx_s[s] = BID_S[s*SIDW + IDW +: MIW];
            bad_s[s]  = BVALID_S[s] && (int'(midx_s[s]) >= NM);
        end
    end

    for (genvar m = 0; m < NM; m++) begin : g_master
        logic [NS:0]        req_s;
        logic [NS:0]        grant_s;
        logic [GW-1:0]      gidx_s;
        logic               any_s;
        logic               load_s;
        logic [IDW-1:0]     win_id_s;
        resp_t              win_resp_s;
        logic               bvalid_r;
        logic [IDW-1:0]     bid_r;
        logic [RESP_W-1:0]  bresp_r;
        logic [IDW-1:0]     q_mem_r [DECERR_DEPTH];
        logic [AW-1:0]      q_wr_r;
        logic [AW-1:0]      q_rd_r;
        logic [CW-1:0]      q_cnt_r;
        logic               q_full_s;
        logic               q_pop_s;
        logic               q_push_s;

        // Slaves addressing this master, with the DECERR queue as the last requester.
        always_comb begin
            req_s = {(NS+1){1'b0}};
            for (int s = 0; s < NS; s++) begin
                req_s[s] = BVALID_S[s] && (int'(midx_s[s]) == m);
            end
            req_s[NS] = (q_cnt_r != {CW{1'b0}});
        end

        // Slice can accept a new beat when empty or being drained this cycle.
        assign load_s = !bvalid_r || BREADY_M[m];

        axi_rr_arbiter #(.N(NS + 1)) u_arb (
            .ACLK      (ACLK),
            .ARESETn   (ARESETn),
            .req       (req_s),
            .advance   (load_s),
            .grant     (grant_s),
            .grant_idx (gidx_s),
            .any_grant (any_s)
        );

        // Select the winning beat; the queue always answers with DECERR.
        always_comb begin
            win_id_s   = {IDW{1'b0}};
            win_resp_s = OKAY;
            if (int'(gidx_s) == NS) begin
                win_id_s   = q_mem_r[q_rd_r];
                win_resp_s = DECERR;
            end else begin
                for (int s = 0; s < NS; s++) begin
                    if (int'(gidx_s) == s) begin
                        win_id_s   = BID_S[s*SIDW +: IDW];
                        win_resp_s = resp_t'(BRESP_S[s*RESP_W +: RESP_W]);
                    end else begin
                    end
                end
            end
        end

        // A full queue still takes a push when the head leaves in the same cycle.
        assign q_full_s = (q_cnt_r == CW'(DECERR_DEPTH));
        assign q_pop_s  = load_s && grant_s[NS];
        assign q_push_s = decerr_push[m] && (!q_full_s || q_pop_s);

        // DECERR queue pointers and occupancy.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                q_wr_r  <= {AW{1'b0}};
                q_rd_r  <= {AW{1'b0}};
                q_cnt_r <= {CW{1'b0}};
            end else begin
                q_wr_r <= q_push_s ? (q_wr_r + AW'(1)) : q_wr_r;
                q_rd_r <= q_pop_s  ? (q_rd_r + AW'(1)) : q_rd_r;
                case ({q_push_s, q_pop_s})
                    2'b10:   q_cnt_r <= q_cnt_r + CW'(1);
                    2'b01:   q_cnt_r <= q_cnt_r - CW'(1);
                    default: q_cnt_r <= q_cnt_r;
                endcase
            end
        end

        // DECERR queue storage.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                for (int i = 0; i < DECERR_DEPTH; i++) begin
                    q_mem_r[i] <= {IDW{1'b0}};
                end
            end else if (q_push_s) begin
                q_mem_r[q_wr_r] <= decerr_id[m*IDW +: IDW];
            end else begin
            end
        end

        // Registered output slice; data holds while the master stalls.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                bvalid_r <= 1'b0;
                bid_r    <= {IDW{1'b0}};
                bresp_r  <= {RESP_W{1'b0}};
            end else if (load_s && any_s) begin
                bvalid_r <= 1'b1;
                bid_r    <= win_id_s;
                bresp_r  <= win_resp_s;
            end else if (load_s) begin
                bvalid_r <= 1'b0;
            end else begin
                bvalid_r <= bvalid_r;
            end
        end

        assign BID_M[m*IDW +: IDW]         = bid_r;
        assign BRESP_M[m*RESP_W +: RESP_W] = bresp_r;
        assign BVALID_M[m]                 = bvalid_r;
        assign decerr_full[m]              = q_full_s;
        assign load_all_s[m]               = load_s;
        assign grant_all_s[m]              = grant_s;
    end

    // Slave ready: granted by its master's arbiter while that slice loads, or
    // swallowed outright when the index is out of range.
    always_comb begin
        bready_s = {NS{1'b0}};
        for (int s = 0; s < NS; s++) begin
            if (!ARESETn) begin
                bready_s[s] = 1'b0;
            end else if (bad_s[s]) begin
                bready_s[s] = 1'b1;
            end else begin
                for (int m = 0; m < NM; m++) begin
                    bready_s[s] = bready_s[s] | (load_all_s[m] && grant_all_s[m][s]);
                end
            end
        end
    end

    assign BREADY_S = bready_s;

    // Sticky bad-index flag, cleared only by reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_bad_id_r <= 1'b0;
        end else if (|bad_s) begin
            err_bad_id_r <= 1'b1;
        end else begin
            err_bad_id_r <= err_bad_id_r;
        end
    end

    assign err_bad_id = err_bad_id_r;

endmodule

// File: tb/tb_axi_bresp_router.sv
// ---------------------------------------------------------------------------
// tb_axi_bresp_router
// Three masters, two slaves: the master index field is two bits wide, so an
// index of 3 is out of range and exercises the bad-ID path.
// ---------------------------------------------------------------------------
module tb_axi_bresp_router;

    localparam int NM    = 3;
    localparam int NS    = 2;
    localparam int IDW   = 4;
    localparam int SIDW  = 8;
    localparam int DEPTH = 4;

    logic                ACLK;
    logic                ARESETn;
    logic [NS*SIDW-1:0]  BID_S;
    logic [NS*2-1:0]     BRESP_S;
    logic [NS-1:0]       BVALID_S;
    logic [NS-1:0]       BREADY_S;
    logic [NM*IDW-1:0]   BID_M;
    logic [NM*2-1:0]     BRESP_M;
    logic [NM-1:0]       BVALID_M;
    logic [NM-1:0]       BREADY_M;
    logic [NM-1:0]       decerr_push;
    logic [NM*IDW-1:0]   decerr_id;
    logic [NM-1:0]       decerr_full;
    logic                err_bad_id;

    axi_bresp_router #(
        .NM(NM), .NS(NS), .IDW(IDW), .SIDW(SIDW), .DECERR_DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .decerr_push(decerr_push), .decerr_id(decerr_id), .decerr_full(decerr_full),
        .err_bad_id(err_bad_id)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        BVALID_S    = 2'b00;
        BID_S       = 16'h0000;
        BRESP_S     = 4'h0;
        BREADY_M    = 3'b111;
        decerr_push = 3'b000;
        decerr_id   = 12'h000;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        ARESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic sample_after_edge();
        @(posedge ACLK);
        #1;
    endtask

    typedef struct {
        logic [1:0] vs;
        logic [7:0] id0;
        logic [1:0] rs0;
        logic [7:0] id1;
        logic [1:0] rs1;
        logic [2:0] rdym;
        logic [2:0] push;
        logic [3:0] pid;
        logic [1:0] e_rdys;
        logic [2:0] e_vm;
        logic [3:0] e_id0;
        logic [1:0] e_r0;
        logic [3:0] e_id1;
        logic [1:0] e_r1;
        logic [2:0] e_full;
    } vec_t;

    vec_t vecs[15];

    // Reference model state for the random phase.
    int         mptr  [NM];
    bit         mv    [NM];
    int         mid   [NM];
    int         mresp [NM];
    logic [3:0] mq    [NM][$];
    bit         merr;

    initial begin
        logic [2:0] evm;
        logic [2:0] efull;
        logic [1:0] erdy;
        bit         load [NM];
        int         win  [NM];
        int         sm, r;
        bit         has;

        //             vs     id0    rs0   id1    rs1   rdym    push    pid   rdys   vm      id0   r0    id1   r1    full
        vecs[0]  = '{2'b10, 8'h00, 2'd0, 8'h13, 2'd0, 3'b111, 3'b000, 4'd0, 2'b10, 3'b010, 4'd0, 2'd0, 4'd3, 2'd0, 3'b000};
        vecs[1]  = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b000, 4'd0, 2'd0, 4'd0, 2'd0, 3'b000};
        vecs[2]  = '{2'b11, 8'h01, 2'd1, 8'h02, 2'd2, 3'b111, 3'b000, 4'd0, 2'b01, 3'b001, 4'd1, 2'd1, 4'd0, 2'd0, 3'b000};
        vecs[3]  = '{2'b11, 8'h01, 2'd1, 8'h02, 2'd2, 3'b111, 3'b000, 4'd0, 2'b10, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b000};
        vecs[4]  = '{2'b11, 8'h01, 2'd1, 8'h02, 2'd2, 3'b111, 3'b000, 4'd0, 2'b01, 3'b001, 4'd1, 2'd1, 4'd0, 2'd0, 3'b000};
        vecs[5]  = '{2'b11, 8'h01, 2'd1, 8'h02, 2'd2, 3'b111, 3'b000, 4'd0, 2'b10, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b000};
        vecs[6]  = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b110, 3'b001, 4'd5, 2'b00, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b000};
        vecs[7]  = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b110, 3'b001, 4'd6, 2'b00, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b000};
        vecs[8]  = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b110, 3'b001, 4'd7, 2'b00, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b000};
        vecs[9]  = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b110, 3'b001, 4'd8, 2'b00, 3'b001, 4'd2, 2'd2, 4'd0, 2'd0, 3'b001};
        vecs[10] = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b001, 4'd5, 2'd3, 4'd0, 2'd0, 3'b000};
        vecs[11] = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b001, 4'd6, 2'd3, 4'd0, 2'd0, 3'b000};
        vecs[12] = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b001, 4'd7, 2'd3, 4'd0, 2'd0, 3'b000};
        vecs[13] = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b001, 4'd8, 2'd3, 4'd0, 2'd0, 3'b000};
        vecs[14] = '{2'b00, 8'h00, 2'd0, 8'h00, 2'd0, 3'b111, 3'b000, 4'd0, 2'b00, 3'b000, 4'd0, 2'd0, 4'd0, 2'd0, 3'b000};

        // ---------------- reset state ----------------
        ARESETn = 1'b0;
        idle_inputs();
        #2;
        chk("reset_bvalid_m", BVALID_M, 3'b000);
        chk("reset_bid_m", BID_M, 12'h000);
        chk("reset_bresp_m", BRESP_M, 6'h00);
        chk("reset_bready_s", BREADY_S, 2'b00);
        chk("reset_err_bad_id", err_bad_id, 1'b0);
        chk("reset_decerr_full", decerr_full, 3'b000);
        do_reset();

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i < 15; i++) begin
            BVALID_S    = vecs[i].vs;
            BID_S       = {vecs[i].id1, vecs[i].id0};
            BRESP_S     = {vecs[i].rs1, vecs[i].rs0};
            BREADY_M    = vecs[i].rdym;
            decerr_push = vecs[i].push;
            decerr_id   = {8'h00, vecs[i].pid};
            #1;
            chk($sformatf("vec%0d_bready_s", i), BREADY_S, vecs[i].e_rdys);
            sample_after_edge();
            chk($sformatf("vec%0d_bvalid_m", i), BVALID_M, vecs[i].e_vm);
            if (vecs[i].e_vm[0]) begin
                chk($sformatf("vec%0d_bid_m0", i), BID_M[3:0], vecs[i].e_id0);
                chk($sformatf("vec%0d_bresp_m0", i), BRESP_M[1:0], vecs[i].e_r0);
            end
            if (vecs[i].e_vm[1]) begin
                chk($sformatf("vec%0d_bid_m1", i), BID_M[7:4], vecs[i].e_id1);
                chk($sformatf("vec%0d_bresp_m1", i), BRESP_M[3:2], vecs[i].e_r1);
            end
            chk($sformatf("vec%0d_decerr_full", i), decerr_full, vecs[i].e_full);
            @(negedge ACLK);
        end

        // ---------------- backpressure ----------------
        do_reset();
        BVALID_S = 2'b01; BID_S[7:0] = 8'h01; BRESP_S[1:0] = 2'd0;
        #1;
        chk("bp_first_bready_s", BREADY_S, 2'b01);
        sample_after_edge();
        chk("bp_first_bid_m0", BID_M[3:0], 4'd1);
        @(negedge ACLK);
        BID_S[7:0] = 8'h04; BRESP_S[1:0] = 2'd2; BREADY_M[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_stall_bready_s0", BREADY_S[0], 1'b0);
            sample_after_edge();
            chk("bp_stall_bvalid_m0", BVALID_M[0], 1'b1);
            chk("bp_stall_bid_m0", BID_M[3:0], 4'd1);
            chk("bp_stall_bresp_m0", BRESP_M[1:0], 2'd0);
            @(negedge ACLK);
        end
        BREADY_M[0] = 1'b1;
        #1;
        chk("bp_release_bready_s0", BREADY_S[0], 1'b1);
        sample_after_edge();
        chk("bp_release_bid_m0", BID_M[3:0], 4'd4);
        chk("bp_release_bresp_m0", BRESP_M[1:0], 2'd2);
        @(negedge ACLK);
        idle_inputs();

        // ---------------- bad master index ----------------
        do_reset();
        BVALID_S = 2'b01; BID_S[7:0] = 8'h33;
        #1;
        chk("bad_bready_s0", BREADY_S[0], 1'b1);
        sample_after_edge();
        chk("bad_bvalid_m", BVALID_M, 3'b000);
        chk("bad_err_set", err_bad_id, 1'b1);
        @(negedge ACLK);
        idle_inputs();
        repeat (3) @(posedge ACLK);
        #1;
        chk("bad_err_sticky", err_bad_id, 1'b1);
        do_reset();
        #1;
        chk("bad_err_cleared", err_bad_id, 1'b0);

        // ---------------- reset mid-stream ----------------
        @(negedge ACLK);
        BVALID_S = 2'b11; BID_S = {8'h13, 8'h01}; BRESP_S = 4'b0000;
        sample_after_edge();
        chk("rst_pre_bvalid_m", BVALID_M, 3'b011);
        @(negedge ACLK);
        BREADY_M = 3'b000; decerr_push = 3'b001; decerr_id = 12'h009;
        sample_after_edge();
        ARESETn = 1'b0;
        #1;
        chk("rst_bvalid_m", BVALID_M, 3'b000);
        chk("rst_bid_m", BID_M, 12'h000);
        chk("rst_bresp_m", BRESP_M, 6'h00);
        chk("rst_bready_s", BREADY_S, 2'b00);
        chk("rst_decerr_full", decerr_full, 3'b000);
        @(negedge ACLK);
        ARESETn = 1'b1;
        BVALID_S = 2'b11; BID_S = {8'h02, 8'h01}; BREADY_M = 3'b111;
        decerr_push = 3'b000; decerr_id = 12'h000;
        #1;
        chk("rst_after_ptr_bready_s", BREADY_S, 2'b01);
        sample_after_edge();
        chk("rst_after_bid_m0", BID_M[3:0], 4'd1);
        @(negedge ACLK);
        idle_inputs();
        sample_after_edge();
        chk("rst_after_queue_empty", BVALID_M, 3'b000);
        @(negedge ACLK);

        // ---------------- randomized against reference model ----------------
        do_reset();
        for (int m = 0; m < NM; m++) begin
            mptr[m] = 0; mv[m] = 1'b0; mid[m] = 0; mresp[m] = 0;
            mq[m].delete();
        end
        merr = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            BVALID_S = 2'($urandom_range(0, 3));
            for (int s = 0; s < NS; s++) begin
                sm = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
                BID_S[s*8 +: 8]   = {2'b00, 2'(sm), 4'($urandom_range(0, 15))};
                BRESP_S[s*2 +: 2] = 2'($urandom_range(0, 3));
            end
            for (int m = 0; m < NM; m++) begin
                BREADY_M[m]    = ($urandom_range(0, 3) != 0);
                decerr_push[m] = ($urandom_range(0, 2) == 0);
            end
            decerr_id = 12'($urandom_range(0, 4095));
            #1;
            // Decide each master's winner from the rules.
            for (int m = 0; m < NM; m++) begin
                load[m] = !mv[m] || BREADY_M[m];
                win[m]  = -1;
                for (int k = 0; k <= NS; k++) begin
                    r = (mptr[m] + k) % (NS + 1);
                    if (r < NS) has = BVALID_S[r] && (int'(BID_S[r*8 +: 8] >> 4) % 4 == m);
                    else        has = (mq[m].size() > 0);
                    if (win[m] < 0 && has) win[m] = r;
                end
            end
            erdy = 2'b00;
            for (int s = 0; s < NS; s++) begin
                sm = int'(BID_S[s*8 +: 8] >> 4) % 4;
                if (BVALID_S[s] && sm >= NM) begin
                    erdy[s] = 1'b1;
                    merr    = 1'b1;
                end else if (BVALID_S[s] && load[sm] && win[sm] == s) begin
                    erdy[s] = 1'b1;
                end
            end
            chk("rnd_bready_s", BREADY_S, erdy);
            for (int m = 0; m < NM; m++) begin
                if (load[m]) begin
                    if (win[m] == NS) begin
                        mv[m] = 1'b1; mid[m] = int'(mq[m].pop_front()); mresp[m] = 3;
                        mptr[m] = (win[m] + 1) % (NS + 1);
                    end else if (win[m] >= 0) begin
                        mv[m] = 1'b1;
                        mid[m] = int'(BID_S[win[m]*8 +: 8]) % 16;
                        mresp[m] = int'(BRESP_S[win[m]*2 +: 2]);
                        mptr[m] = (win[m] + 1) % (NS + 1);
                    end else begin
                        mv[m] = 1'b0;
                    end
                end
                if (decerr_push[m] && mq[m].size() < DEPTH)
                    mq[m].push_back(decerr_id[m*4 +: 4]);
            end
            sample_after_edge();
            for (int m = 0; m < NM; m++) begin
                evm[m]   = mv[m];
                efull[m] = (mq[m].size() == DEPTH);
            end
            chk("rnd_bvalid_m", BVALID_M, evm);
            for (int m = 0; m < NM; m++) begin
                if (mv[m]) begin
                    chk($sformatf("rnd_bid_m%0d", m), BID_M[m*4 +: 4], mid[m]);
                    chk($sformatf("rnd_bresp_m%0d", m), BRESP_M[m*2 +: 2], mresp[m]);
                end
            end
            chk("rnd_decerr_full", decerr_full, efull);
            chk("rnd_err_bad_id", err_bad_id, merr);
            @(negedge ACLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
